// File: rtl/img_rsz_pxl_fwd.sv
// rtl/img_rsz_pxl_fwd.sv - resized pixel forwarder: streams executed blocks in raster order and flushes them
module img_rsz_pxl_fwd #(
    parameter int RSZ_IMG_WIDTH_SIZE   = 8,
    parameter int RSZ_IMG_HEIGHT_SIZE  = 8,
    parameter int RSZ_IMG_WIDTH_IDX_W  = $clog2(RSZ_IMG_WIDTH_SIZE),
    parameter int RSZ_IMG_HEIGHT_IDX_W = $clog2(RSZ_IMG_HEIGHT_SIZE),
    parameter int PXL_PRIM_COLOR_NUM   = 1,
    parameter int PXL_PRIM_COLOR_W     = 8,
    parameter int BLK_SUM_MAX_W        = 16
) (
    input  logic                                Clk,
    input  logic                                Reset,
    input  logic                                BlkIsExec [RSZ_IMG_HEIGHT_SIZE-1:0][RSZ_IMG_WIDTH_SIZE-1:0],
    input  logic [PXL_PRIM_COLOR_NUM-1:0][RSZ_IMG_HEIGHT_SIZE-1:0][RSZ_IMG_WIDTH_SIZE-1:0][BLK_SUM_MAX_W-1:0] FcBlkBuf,
    output logic [RSZ_IMG_WIDTH_SIZE-1:0]       FlushBlkXMsk,
    output logic [RSZ_IMG_HEIGHT_SIZE-1:0]      FlushBlkYMsk,
    output logic                                FlushVld,
    output logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0] RszPxlData,
    output logic [RSZ_IMG_WIDTH_IDX_W-1:0]      RszPxlX,
    output logic [RSZ_IMG_HEIGHT_IDX_W-1:0]     RszPxlY,
    output logic                                RszPxlLast,
    output logic                                RszPxlVld,
    input  logic                                RszPxlRdy,
    output logic                                FrmDone
);

    localparam logic [RSZ_IMG_WIDTH_IDX_W-1:0]  X_LAST = RSZ_IMG_WIDTH_IDX_W'(RSZ_IMG_WIDTH_SIZE - 1);
    localparam logic [RSZ_IMG_HEIGHT_IDX_W-1:0] Y_LAST = RSZ_IMG_HEIGHT_IDX_W'(RSZ_IMG_HEIGHT_SIZE - 1);
    localparam logic [RSZ_IMG_WIDTH_SIZE-1:0]   X_ONE  = RSZ_IMG_WIDTH_SIZE'(1);
    localparam logic [RSZ_IMG_HEIGHT_SIZE-1:0]  Y_ONE  = RSZ_IMG_HEIGHT_SIZE'(1);

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                                          state, state_nxt;
    logic [RSZ_IMG_WIDTH_IDX_W-1:0]                  cur_x, cur_x_nxt;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0]                 cur_y, cur_y_nxt;
    logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0] data_nxt;
    logic [RSZ_IMG_WIDTH_IDX_W-1:0]                  pxl_x_nxt;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0]                 pxl_y_nxt;
    logic                                            last_nxt;
    logic                                            vld_nxt;
    logic                                            flush_vld_nxt;
    logic [RSZ_IMG_WIDTH_SIZE-1:0]                   xmsk_nxt;
    logic [RSZ_IMG_HEIGHT_SIZE-1:0]                  ymsk_nxt;
    logic                                            frm_done_nxt;
    logic                                            at_x_last;
    logic                                            at_y_last;

    assign at_x_last = (cur_x == X_LAST);
    assign at_y_last = (cur_y == Y_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= ST_WAIT;
            cur_x        <= '0;
            cur_y        <= '0;
            RszPxlData   <= '0;
            RszPxlX      <= '0;
            RszPxlY      <= '0;
            RszPxlLast   <= 1'b0;
            RszPxlVld    <= 1'b0;
            FlushVld     <= 1'b0;
            FlushBlkXMsk <= '0;
            FlushBlkYMsk <= '0;
            FrmDone      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cur_x        <= cur_x_nxt;
            cur_y        <= cur_y_nxt;
            RszPxlData   <= data_nxt;
            RszPxlX      <= pxl_x_nxt;
            RszPxlY      <= pxl_y_nxt;
            RszPxlLast   <= last_nxt;
            RszPxlVld    <= vld_nxt;
            FlushVld     <= flush_vld_nxt;
            FlushBlkXMsk <= xmsk_nxt;
            FlushBlkYMsk <= ymsk_nxt;
            FrmDone      <= frm_done_nxt;
        end
    end

    // Payload registers hold their value in SEND so the stream stays stable under backpressure;
    // flush strobe, masks and frame-done default to 0 so they are single-cycle pulses.
    always_comb begin
        state_nxt     = state;
        cur_x_nxt     = cur_x;
        cur_y_nxt     = cur_y;
        data_nxt      = RszPxlData;
        pxl_x_nxt     = RszPxlX;
        pxl_y_nxt     = RszPxlY;
        last_nxt      = RszPxlLast;
        vld_nxt       = RszPxlVld;
        flush_vld_nxt = 1'b0;
        xmsk_nxt      = '0;
        ymsk_nxt      = '0;
        frm_done_nxt  = 1'b0;
        unique case (state)
            ST_WAIT: begin
                if (BlkIsExec[cur_y][cur_x]) begin
                    for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
                        data_nxt[c] = FcBlkBuf[c][cur_y][cur_x][PXL_PRIM_COLOR_W-1:0];
                    end
                    pxl_x_nxt = cur_x;
                    pxl_y_nxt = cur_y;
                    last_nxt  = at_x_last && at_y_last;
                    vld_nxt   = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (RszPxlRdy) begin
                    vld_nxt       = 1'b0;
                    flush_vld_nxt = 1'b1;
                    xmsk_nxt      = X_ONE << cur_x;
                    ymsk_nxt      = Y_ONE << cur_y;
                    // Cursor moves past the flushed block now, so its flag (cleared a cycle later) is never re-read.
                    if (at_x_last) begin
                        cur_x_nxt = '0;
                        if (at_y_last) begin
                            cur_y_nxt    = '0;
                            frm_done_nxt = 1'b1;
                        end else begin
                            cur_y_nxt = cur_y + 1'b1;
                        end
                    end else begin
                        cur_x_nxt = cur_x + 1'b1;
                    end
                    state_nxt = ST_WAIT;
                end
            end
            default: state_nxt = ST_WAIT;
        endcase
    end

endmodule

// File: tb/tb_img_rsz_pxl_fwd.sv
// tb/tb_img_rsz_pxl_fwd.sv - directed self-checking bench for img_rsz_pxl_fwd on a 2x2 grid with 3 colours
module tb_img_rsz_pxl_fwd;

    localparam int W  = 2;
    localparam int H  = 2;
    localparam int XW = 1;
    localparam int YW = 1;
    localparam int C  = 3;
    localparam int PW = 8;
    localparam int BW = 16;

    logic                             clk = 1'b0;
    logic                             reset;
    logic                             blk_is_exec [H-1:0][W-1:0];
    logic [C-1:0][H-1:0][W-1:0][BW-1:0] fc_blk_buf;
    logic [W-1:0]                     flush_xmsk;
    logic [H-1:0]                     flush_ymsk;
    logic                             flush_vld;
    logic [C-1:0][PW-1:0]             pxl_data;
    logic [XW-1:0]                    pxl_x;
    logic [YW-1:0]                    pxl_y;
    logic                             pxl_last;
    logic                             pxl_vld;
    logic                             pxl_rdy;
    logic                             frm_done;

    int vectors = 0;
    int miscompares = 0;

    img_rsz_pxl_fwd #(
        .RSZ_IMG_WIDTH_SIZE(W), .RSZ_IMG_HEIGHT_SIZE(H),
        .RSZ_IMG_WIDTH_IDX_W(XW), .RSZ_IMG_HEIGHT_IDX_W(YW),
        .PXL_PRIM_COLOR_NUM(C), .PXL_PRIM_COLOR_W(PW), .BLK_SUM_MAX_W(BW)
    ) dut (
        .Clk(clk), .Reset(reset), .BlkIsExec(blk_is_exec), .FcBlkBuf(fc_blk_buf),
        .FlushBlkXMsk(flush_xmsk), .FlushBlkYMsk(flush_ymsk), .FlushVld(flush_vld),
        .RszPxlData(pxl_data), .RszPxlX(pxl_x), .RszPxlY(pxl_y), .RszPxlLast(pxl_last),
        .RszPxlVld(pxl_vld), .RszPxlRdy(pxl_rdy), .FrmDone(frm_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [C*PW-1:0] pat(input int x, input int y);
        logic [7:0] b;
        b = 8'(16 * y + x);
        return {b + 8'h80, b + 8'h40, b};
    endfunction

    task automatic set_flags(input logic v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                blk_is_exec[y][x] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pxl_rdy = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic handshake(input int ex, input int ey, input logic elast, input logic [C*PW-1:0] edata);
        int n;
        n = 0;
        while (!pxl_vld && n < 40) begin
            step();
            n++;
        end
        chk("vld_seen", 64'(pxl_vld), 64'd1);
        chk("pxl_x", 64'(pxl_x), 64'(ex));
        chk("pxl_y", 64'(pxl_y), 64'(ey));
        chk("pxl_last", 64'(pxl_last), 64'(elast));
        chk("pxl_data", 64'(pxl_data), 64'(edata));
        chk("no_flush_in_send", 64'(flush_vld), 64'd0);
        pxl_rdy = 1'b1;
        step();
        pxl_rdy = 1'b0;
        chk("flush_vld", 64'(flush_vld), 64'd1);
        chk("flush_xmsk", 64'(flush_xmsk), 64'(1 << ex));
        chk("flush_ymsk", 64'(flush_ymsk), 64'(1 << ey));
        chk("frm_done", 64'(frm_done), 64'(elast));
        chk("vld_drop", 64'(pxl_vld), 64'd0);
    endtask

    initial begin
        logic [C*PW-1:0] held;
        int nv, nf, k;

        reset = 1'b1;
        pxl_rdy = 1'b0;
        set_flags(1'b0);
        for (int c = 0; c < C; c++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    fc_blk_buf[c][y][x] = {8'(8'h11 * (c + 1)), 8'(16 * y + x + 64 * c)};
        do_reset();
        chk("rst_vld", 64'(pxl_vld), 64'd0);
        chk("rst_flush", 64'(flush_vld), 64'd0);
        chk("rst_masks", 64'({flush_xmsk, flush_ymsk}), 64'd0);
        chk("rst_payload", 64'({pxl_data, pxl_x, pxl_y, pxl_last}), 64'd0);
        chk("rst_frm_done", 64'(frm_done), 64'd0);

        // Raster order over one full frame
        set_flags(1'b1);
        handshake(0, 0, 1'b0, pat(0, 0));
        handshake(1, 0, 1'b0, pat(1, 0));
        handshake(0, 1, 1'b0, pat(0, 1));
        handshake(1, 1, 1'b1, pat(1, 1));
        step();
        chk("flush_one_cycle", 64'(flush_vld), 64'd0);
        chk("masks_idle", 64'({flush_xmsk, flush_ymsk}), 64'd0);
        chk("frm_done_one_cycle", 64'(frm_done), 64'd0);

        // Out-of-order exec: only the cursor block's flag matters
        set_flags(1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) step();
        blk_is_exec[0][1] = 1'b1;
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (pxl_vld) nv++;
        end
        chk("no_early_output", 64'(nv), 64'd0);
        blk_is_exec[0][0] = 1'b1;
        step();
        chk("latency_one_cycle", 64'(pxl_vld), 64'd1);
        handshake(0, 0, 1'b0, pat(0, 0));
        handshake(1, 0, 1'b0, pat(1, 0));
        set_flags(1'b0);

        // Backpressure with 8'hA5 pending on block (0,1)
        fc_blk_buf[0][1][0] = 16'h77A5;
        blk_is_exec[1][0] = 1'b1;
        step();
        step();
        chk("bp_vld", 64'(pxl_vld), 64'd1);
        held = pxl_data;
        chk("bp_data_lsb", 64'(pxl_data[0]), 64'h A5);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!pxl_vld || pxl_data !== held || pxl_x !== 1'b0 || pxl_y !== 1'b1 || flush_vld) k++;
        end
        chk("bp_stable_cycles", 64'(k), 64'd0);
        handshake(0, 1, 1'b0, held);
        step();
        chk("bp_single_flush", 64'(flush_vld), 64'd0);
        blk_is_exec[1][0] = 1'b0;

        // Independent per-colour truncation on block (1,1)
        fc_blk_buf[0][1][1] = 16'h12C8;
        fc_blk_buf[1][1][1] = 16'hAB3C;
        fc_blk_buf[2][1][1] = 16'h0001;
        blk_is_exec[1][1] = 1'b1;
        handshake(1, 1, 1'b1, {8'h01, 8'h3C, 8'hC8});
        blk_is_exec[1][1] = 1'b0;

        // Reset while a pixel is pending
        fc_blk_buf[0][1][0] = 16'h0010;
        fc_blk_buf[0][1][1] = 16'h0011;
        fc_blk_buf[1][1][1] = 16'h0051;
        fc_blk_buf[2][1][1] = 16'h0091;
        set_flags(1'b1);
        handshake(0, 0, 1'b0, pat(0, 0));
        step();
        chk("pre_reset_vld", 64'(pxl_vld), 64'd1);
        chk("pre_reset_x", 64'(pxl_x), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_vld", 64'(pxl_vld), 64'd0);
        chk("mid_rst_flush", 64'(flush_vld), 64'd0);
        chk("mid_rst_xy", 64'({pxl_x, pxl_y}), 64'd0);
        handshake(0, 0, 1'b0, pat(0, 0));

        // Two back-to-back frames with Rdy held high
        do_reset();
        pxl_rdy = 1'b1;
        nv = 0;
        nf = 0;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (pxl_vld) begin
                if (pxl_x !== XW'(nv % W) || pxl_y !== YW'((nv / W) % H)) k++;
                nv++;
            end
            if (frm_done) nf++;
        end
        chk("b2b_pixels", 64'(nv), 64'(2 * W * H));
        chk("b2b_frm_done", 64'(nf), 64'd2);
        chk("b2b_order_errs", 64'(k), 64'd0);
        step();
        chk("b2b_wrap_vld", 64'(pxl_vld), 64'd1);
        chk("b2b_wrap_xy", 64'({pxl_x, pxl_y}), 64'd0);
        pxl_rdy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
